// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit -- multi-cycle RISC-V M-extension execute unit.
//
// Runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU one operation at a time.
// Multiply is shift-add over operand magnitudes and divide is restoring.
// Each produces one bit per cycle, so an operation takes XLEN CALC cycles.
// Divide-by-zero and signed overflow skip CALC and finish on the next cycle.
//
// Optional build macro: MULDIV_FAST_MUL_EN
//   When it is defined, the four multiplies use a single-cycle XLEN x XLEN
//   product that is registered straight into DONE. Divide is unchanged.
//
// Ports:
//   clk, reset (async, active-low)
//   start, op[2:0] (funct3), rs1_data, rs2_data, rd_addr_in : issue request
//   flush        : abort the in-flight operation, return to IDLE
//   busy         : state != IDLE
//   done         : one-cycle pulse, result / rd_addr_out valid
//   result       : registered result, held until the next DONE
//   rd_addr_out  : registered destination, held until the next DONE
//   stall        : hold IF/ID and bubble ID/EX

module rv_muldiv_unit #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [XLEN-1:0]    rs1_data,
  input  logic [XLEN-1:0]    rs2_data,
  input  logic [RADDR_W-1:0] rd_addr_in,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    result,
  output logic [RADDR_W-1:0] rd_addr_out,
  output logic               stall
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*XLEN-1:0]    acc;      // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]      opnd_q;   // multiplicand magnitude or divisor magnitude
  logic [2:0]           op_q;
  logic                 neg_res;  // negate product / quotient
  logic                 neg_rem;  // negate remainder
  logic [RADDR_W-1:0]   rd_q;

  // ---------------- issue-side decode ----------------
  logic            accept, is_div, a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, early_result;

  assign accept   = (state == IDLE) && start && !flush;
  assign is_div   = op[2];
  // MULHU is the only unsigned-A multiply. B is signed only for MUL and MULH.
  assign a_signed = is_div ? ~op[0] : (op != 3'd3);
  assign b_signed = is_div ? ~op[0] : ~op[1];
  assign a_neg    = a_signed & rs1_data[XLEN-1];
  assign b_neg    = b_signed & rs2_data[XLEN-1];
  // The most-negative value keeps its bit pattern, which is already its
  // correct unsigned magnitude.
  assign a_mag    = a_neg ? -rs1_data : rs1_data;
  assign b_mag    = b_neg ? -rs2_data : rs2_data;

  assign div_zero = is_div && (rs2_data == '0);
  assign div_ovf  = is_div && !op[0] && (rs1_data == MOST_NEG) && (rs2_data == '1);
  // For overflow, DIV returns the dividend (the most-negative value) and REM returns 0.
  assign early_result = div_zero ? (op[1] ? rs1_data : '1)
                                 : (op[1] ? '0 : rs1_data);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] a_ext, b_ext, fast_prod;
  logic [XLEN-1:0]   fast_result;
  assign a_ext       = {{XLEN{a_neg}}, rs1_data};
  assign b_ext       = {{XLEN{b_neg}}, rs2_data};
  assign fast_prod   = a_ext * b_ext;  // truncated to 2*XLEN, exact for all sign mixes
  assign fast_result = (op == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

  // ---------------- one iteration ----------------
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] acc_nxt;

  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  // The carry out of mul_sum becomes the new top accumulator bit as the
  // accumulator shifts right.
  assign acc_nxt = op_q[2]
    ? (div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                      : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1})
    : {mul_sum, acc[XLEN-1:1]};

  // Sign correction is applied to the final iteration's output so that the
  // registered result is already valid in DONE.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_result;

  assign prod_fix = neg_res ? -acc_nxt : acc_nxt;
  assign quo_fix  = neg_res ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
  assign rem_fix  = neg_rem ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    final_result = prod_fix[2*XLEN-1:XLEN];
    case (op_q)
      3'd0:       final_result = prod_fix[XLEN-1:0];
      3'd4, 3'd5: final_result = quo_fix;
      3'd6, 3'd7: final_result = rem_fix;
      default:    final_result = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  // ---------------- state and datapath registers ----------------
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      opnd_q      <= '0;
      op_q        <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      rd_q        <= '0;
      result      <= '0;
      rd_addr_out <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q    <= op;
          rd_q    <= rd_addr_in;
          neg_res <= a_neg ^ b_neg;
          neg_rem <= a_neg;
          if (div_zero || div_ovf) begin
            result      <= early_result;
            rd_addr_out <= rd_addr_in;
            state       <= DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!is_div) begin
            result      <= fast_result;
            rd_addr_out <= rd_addr_in;
            state       <= DONE;
`endif
          end else begin
            // Multiply starts with the multiplier in the low half.
            // Divide starts with the dividend there.
            acc    <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
            opnd_q <= is_div ? b_mag : a_mag;
            cnt    <= CNT_W'(XLEN);
            state  <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            result      <= final_result;
            rd_addr_out <= rd_q;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign stall = accept || (state == CALC);

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb_rv_muldiv_unit -- self-checking bench for rv_muldiv_unit (XLEN=32).
// When stimulus is driven, the expected result and rd are pushed to a
// scoreboard queue. They are popped and compared when done is seen.
// Outputs are sampled on the falling clock edge.

module tb_rv_muldiv_unit;

  localparam int XLEN = 32;
  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3,
                         OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
  localparam logic [31:0] MOST_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1_data = '0, rs2_data = '0;
  logic [4:0]  rd_addr_in = '0;
  logic        flush = 1'b0;
  logic        busy, done, stall;
  logic [31:0] result;
  logic [4:0]  rd_addr_out;

  rv_muldiv_unit #(.XLEN(XLEN), .RADDR_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr_in(rd_addr_in),
    .flush(flush), .busy(busy), .done(done), .result(result),
    .rd_addr_out(rd_addr_out), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_res = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model using plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb_, ua, ub, p;
    sa  = {{32{a[31]}}, a};
    sb_ = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    p   = '0;
    case (o)
      OP_MUL:    begin p = sa * sb_; return p[31:0];  end
      OP_MULH:   begin p = sa * sb_; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub;  return p[63:32]; end
      OP_MULHU:  begin p = ua * ub;  return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MOST_NEG && b == 32'hFFFF_FFFF) return MOST_NEG;
        p = sa / sb_; return p[31:0];
      end
      OP_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == MOST_NEG && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb_; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && (b == 0 || (!o[0] && a == MOST_NEG && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[2]) return 1;
`endif
    return XLEN + 1;
  endfunction

  // Issue one operation and follow it to done. If poke > 0, a foreign start
  // is pulsed in that cycle after acceptance; the unit must ignore it.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int poke);
    int   lat, n;
    bit   seen, stall_ok;
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_addr_in = rd;
    e.res = model(o, a, b);
    e.rd  = rd;
    sb.push_back(e);
    lat = latency(o, a, b);
    #1 check({tag, "_stall_accept"}, stall, 1);
    @(posedge clk);
    #1 start = 1'b0; rs1_data = $urandom; rs2_data = $urandom; rd_addr_in = 5'($urandom);
    n = 0; seen = 0; stall_ok = 1;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1;
      else if (stall !== 1'b1) stall_ok = 0;
      if (poke > 0 && n == poke) begin
        start = 1'b1; op = OP_DIVU; rs1_data = 32'd999; rs2_data = 32'd3; rd_addr_in = 5'd31;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, n, lat);
    check({tag, "_stall_calc"}, stall_ok, 1);
    check({tag, "_stall_done"}, stall, 0);
    e = sb.pop_front();
    if (seen) begin
      check({tag, "_result"}, result, e.res);
      check({tag, "_rd"}, rd_addr_out, e.rd);
      last_res = e.res;
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    bit saw;

    // Reset state.
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stall", stall, 0);
    check("rst_result", result, 0);
    check("rst_rd", rd_addr_out, 0);
    @(negedge clk);
    reset = 1'b1;

    // Multiply.
    run_op("mul",    OP_MUL,    32'd7,        32'hFFFF_FFFD, 5'd5,  0);
    run_op("mulh",   OP_MULH,   32'd7,        32'hFFFF_FFFD, 5'd6,  0);
    run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 0);
    run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFE, 32'd3,        5'd8,  0);

    // Divide, including a start pulse that must be ignored during CALC.
    run_op("div",    OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd10, 0);
    run_op("rem",    OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd11, 0);
    run_op("divu",   OP_DIVU, 32'd100,       32'd7, 5'd12, 5);
    run_op("remu",   OP_REMU, 32'd100,       32'd7, 5'd13, 0);

    // Early-out cases.
    run_op("divu_z", OP_DIVU, 32'd5,    32'd0,         5'd14, 0);
    run_op("rem_z",  OP_REM,  32'd7,    32'd0,         5'd15, 0);
    run_op("div_ov", OP_DIV,  MOST_NEG, 32'hFFFF_FFFF, 5'd16, 0);
    run_op("rem_ov", OP_REM,  MOST_NEG, 32'hFFFF_FFFF, 5'd17, 0);

    // Flush mid-CALC: no done, busy drops, result held.
    @(negedge clk);
    start = 1'b1; op = OP_DIV; rs1_data = 32'd1000; rs2_data = 32'd9; rd_addr_in = 5'd20;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", busy, 0);
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw = 1;
    end
    check("flush_no_done", saw, 0);
    check("flush_result", result, last_res);

    // start together with flush is not accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_DIVU; rs1_data = 32'd50; rs2_data = 32'd5;
    #1 check("start_flush_stall", stall, 0);
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    check("start_flush_busy", busy, 0);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; rs1_data = 32'd77; rs2_data = 32'd4; rd_addr_in = 5'd21;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    #1 reset = 1'b0;
    #1;
    check("areset_busy", busy, 0);
    check("areset_done", done, 0);
    check("areset_stall", stall, 0);
    check("areset_result", result, 0);
    @(negedge clk);
    reset = 1'b1;
    run_op("mul_post_rst", OP_MUL, 32'd3, 32'd4, 5'd9, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
